// File: rtl/isa_pkg.sv
// Shared ISA constants: opcode values and ALU_Signals bit positions.
// Used by the issue control, the ALU and the branch unit.
// Defines constants only; there is no timing or backpressure here.
package isa_pkg;

  // Opcode field values (instruction bits 31:27)
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  // Opcodes at or above this value are undefined
  localparam int NUM_OPCODES = 21;

  // Bit positions inside ALU_Signals[21:9]
  localparam int ALU_ADD = 9;
  localparam int ALU_SUB = 10;
  localparam int ALU_CMP = 11;
  localparam int ALU_MUL = 12;
  localparam int ALU_DIV = 13;
  localparam int ALU_MOD = 14;
  localparam int ALU_LSL = 15;
  localparam int ALU_LSR = 16;
  localparam int ALU_ASR = 17;
  localparam int ALU_OR  = 18;
  localparam int ALU_AND = 19;
  localparam int ALU_NOT = 20;
  localparam int ALU_MOV = 21;

endpackage

// File: rtl/alu_op_decoder.sv
// Opcode to one-hot ALU control decode, plus illegal and multi-cycle flags.
// Purely combinational, zero latency.
// No backpressure; the caller registers the result.
module alu_op_decoder
  import isa_pkg::*;
(
  input  logic [4:0]  i_opcode,
  output logic [21:9] o_alu_sig,
  output logic        o_illegal,
  output logic        o_is_multicycle
);

  // Each opcode sets at most one control bit, so the ALU never has to arbitrate
  always_comb begin
    o_alu_sig       = '0;
    o_illegal       = 1'b0;
    o_is_multicycle = 1'b0;
    case (i_opcode)
      OP_ADD:  o_alu_sig[ALU_ADD] = 1'b1;
      OP_SUB:  o_alu_sig[ALU_SUB] = 1'b1;
      OP_MUL:  o_alu_sig[ALU_MUL] = 1'b1;
      OP_DIV: begin
        o_alu_sig[ALU_DIV] = 1'b1;
        o_is_multicycle    = 1'b1;
      end
      OP_MOD: begin
        o_alu_sig[ALU_MOD] = 1'b1;
        o_is_multicycle    = 1'b1;
      end
      OP_CMP:  o_alu_sig[ALU_CMP] = 1'b1;
      OP_AND:  o_alu_sig[ALU_AND] = 1'b1;
      OP_OR:   o_alu_sig[ALU_OR]  = 1'b1;
      OP_NOT:  o_alu_sig[ALU_NOT] = 1'b1;
      OP_MOV:  o_alu_sig[ALU_MOV] = 1'b1;
      OP_LSL:  o_alu_sig[ALU_LSL] = 1'b1;
      OP_LSR:  o_alu_sig[ALU_LSR] = 1'b1;
      OP_ASR:  o_alu_sig[ALU_ASR] = 1'b1;
      // Loads and stores use the adder for address generation
      OP_LD, OP_ST: o_alu_sig[ALU_ADD] = 1'b1;
      // Control-flow ops and nop need no ALU operation
      OP_NOP, OP_BEQ, OP_BGT, OP_B, OP_CALL, OP_RET: o_alu_sig = '0;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID/EX control register: decodes opcode into ALU controls, tracks div/mod occupancy, owns flags_q.
// Latency: 1 cycle decode-to-EX; div/mod occupy EX for DIV_LATENCY cycles.
// Backpressure: id_ready drops while a div/mod is counting, on ex_stall, or on flush.
module alu_ctrl_issue
  import isa_pkg::*;
#(
  parameter int DIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_opcode,
  input  logic        id_imm,
  output logic        id_ready,
  input  logic        ex_stall,
  input  logic        flush,
  input  logic [1:0]  alu_flags,
  output logic [21:9] ALU_Signals,
  output logic        ex_valid,
  output logic        ex_imm,
  output logic        ex_illegal,
  output logic        ex_fire,
  output logic [1:0]  flags_q
);

  localparam logic [3:0] DIV_LOAD = 4'(DIV_LATENCY - 1);

  logic [21:9] r_alu_sig;
  logic        r_valid;
  logic        r_imm;
  logic        r_illegal;
  logic [3:0]  r_cnt;
  logic [1:0]  r_flags;

  logic [21:9] w_dec_sig;
  logic        w_dec_illegal;
  logic        w_dec_multi;
  logic        w_busy;
  logic        w_accept;
  logic        w_fire;

  alu_op_decoder u_dec (
    .i_opcode        (id_opcode),
    .o_alu_sig       (w_dec_sig),
    .o_illegal       (w_dec_illegal),
    .o_is_multicycle (w_dec_multi)
  );

  // The count is only ever nonzero for a live div/mod, but gate with valid anyway
  assign w_busy   = r_valid && (r_cnt != 4'd0);
  assign id_ready = !w_busy && !ex_stall && !flush;
  assign w_accept = id_valid && id_ready;
  // A flush squashes the EX instruction, so it must not complete (nor write flags)
  assign w_fire   = r_valid && (r_cnt == 4'd0) && !ex_stall && !flush;

  // EX register: flush > hold (stall or divide in progress) > load > bubble
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_alu_sig <= '0;
      r_valid   <= 1'b0;
      r_imm     <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= 4'd0;
    end else if (ex_stall || w_busy) begin
      if (!ex_stall && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end else if (w_accept) begin
      r_alu_sig <= w_dec_sig;
      r_valid   <= 1'b1;
      r_imm     <= id_imm;
      r_illegal <= w_dec_illegal;
      r_cnt     <= w_dec_multi ? DIV_LOAD : 4'd0;
    end else begin
      r_alu_sig <= '0;
      r_valid   <= 1'b0;
      r_imm     <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= 4'd0;
    end
  end

  // Architectural flags: captured only when a compare completes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 2'b00;
    end else if (w_fire && r_alu_sig[ALU_CMP]) begin
      r_flags <= alu_flags;
    end
  end

  assign ALU_Signals = r_alu_sig;
  assign ex_valid    = r_valid;
  assign ex_imm      = r_imm;
  assign ex_illegal  = r_illegal;
  assign ex_fire     = w_fire;
  assign flags_q     = r_flags;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue with hand-computed expectations.
// Inputs change and outputs are sampled 2ns after the rising edge.
// Default DIV_LATENCY of 4 is used throughout.
module tb_alu_ctrl_issue;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic        id_imm;
  logic        id_ready;
  logic        ex_stall;
  logic        flush;
  logic [1:0]  alu_flags;
  logic [21:9] ALU_Signals;
  logic        ex_valid;
  logic        ex_imm;
  logic        ex_illegal;
  logic        ex_fire;
  logic [1:0]  flags_q;

  int n_chk;
  int n_err;

  alu_ctrl_issue #(.DIV_LATENCY(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_imm      (id_imm),
    .id_ready    (id_ready),
    .ex_stall    (ex_stall),
    .flush       (flush),
    .alu_flags   (alu_flags),
    .ALU_Signals (ALU_Signals),
    .ex_valid    (ex_valid),
    .ex_imm      (ex_imm),
    .ex_illegal  (ex_illegal),
    .ex_fire     (ex_fire),
    .flags_q     (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // opcode / expected ALU_Signals[21:9] as a 13-bit value (bit 9 = LSB)
  logic [4:0]  vec_op  [10];
  logic [12:0] vec_sig [10];

  initial begin
    n_chk = 0;
    n_err = 0;
    vec_op[0] = 5'd6;  vec_sig[0] = 13'h0400;
    vec_op[1] = 5'd8;  vec_sig[1] = 13'h0800;
    vec_op[2] = 5'd10; vec_sig[2] = 13'h0040;
    vec_op[3] = 5'd11; vec_sig[3] = 13'h0080;
    vec_op[4] = 5'd12; vec_sig[4] = 13'h0100;
    vec_op[5] = 5'd14; vec_sig[5] = 13'h0001;
    vec_op[6] = 5'd15; vec_sig[6] = 13'h0001;
    vec_op[7] = 5'd13; vec_sig[7] = 13'h0000;
    vec_op[8] = 5'd2;  vec_sig[8] = 13'h0008;
    vec_op[9] = 5'd20; vec_sig[9] = 13'h0000;

    reset = 1'b1; id_valid = 1'b0; id_opcode = 5'd0; id_imm = 1'b0;
    ex_stall = 1'b0; flush = 1'b0; alu_flags = 2'b00;
    tick();
    tick();
    chk("rst_sig",   32'(ALU_Signals), 32'h0);
    chk("rst_valid", 32'(ex_valid), 32'h0);
    chk("rst_fire",  32'(ex_fire), 32'h0);
    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_ready", 32'(id_ready), 32'h1);
    reset = 1'b0;

    // single add
    id_valid = 1'b1; id_opcode = 5'd0; id_imm = 1'b1;
    tick();
    chk("add_sig",   32'(ALU_Signals), 32'h0001);
    chk("add_valid", 32'(ex_valid), 32'h1);
    chk("add_fire",  32'(ex_fire), 32'h1);
    chk("add_imm",   32'(ex_imm), 32'h1);

    // back-to-back sub, or, mov
    id_opcode = 5'd1; id_imm = 1'b0;
    #1 chk("b2b_ready0", 32'(id_ready), 32'h1);
    tick();
    chk("sub_sig", 32'(ALU_Signals), 32'h0002);
    id_opcode = 5'd7;
    #1 chk("b2b_ready1", 32'(id_ready), 32'h1);
    tick();
    chk("or_sig", 32'(ALU_Signals), 32'h0200);
    id_opcode = 5'd9;
    #1 chk("b2b_ready2", 32'(id_ready), 32'h1);
    tick();
    chk("mov_sig", 32'(ALU_Signals), 32'h1000);
    chk("mov_imm", 32'(ex_imm), 32'h0);

    // decode table, one op per cycle
    for (int i = 0; i < 10; i++) begin
      id_opcode = vec_op[i];
      tick();
      chk($sformatf("dec_op%0d", vec_op[i]), 32'(ALU_Signals), 32'(vec_sig[i]));
    end

    // divide followed by add waiting in ID
    id_opcode = 5'd3;
    tick();
    chk("div_sig", 32'(ALU_Signals), 32'h0010);
    id_opcode = 5'd0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("div_ready_c%0d", c), 32'(id_ready), (c < 4) ? 32'h0 : 32'h1);
      chk($sformatf("div_fire_c%0d", c), 32'(ex_fire), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("div_hold_c%0d", c), 32'(ALU_Signals), 32'h0010);
      tick();
    end
    chk("div_then_add", 32'(ALU_Signals), 32'h0001);
    chk("div_then_add_fire", 32'(ex_fire), 32'h1);

    // compare with flags 01 at fire
    id_opcode = 5'd5; alu_flags = 2'b01;
    tick();
    chk("cmp_fire", 32'(ex_fire), 32'h1);
    id_valid = 1'b0;
    tick();
    chk("cmp_flags", 32'(flags_q), 32'h1);
    chk("cmp_bubble", 32'(ex_valid), 32'h0);

    // second compare squashed in EX, with an add offered in the flush cycle
    id_valid = 1'b1; id_opcode = 5'd5; alu_flags = 2'b10;
    tick();
    flush = 1'b1; id_opcode = 5'd0;
    #1;
    chk("flush_fire", 32'(ex_fire), 32'h0);
    chk("flush_ready", 32'(id_ready), 32'h0);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_flags", 32'(flags_q), 32'h1);
    chk("flush_sig", 32'(ALU_Signals), 32'h0);

    // divide with a 3-cycle stall in cycles 2..4: fire moves from cycle 4 to 7
    id_valid = 1'b1; id_opcode = 5'd3;
    tick();
    id_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      ex_stall = (c >= 2 && c <= 4);
      #1;
      chk($sformatf("stl_fire_c%0d", c), 32'(ex_fire), (c == 7) ? 32'h1 : 32'h0);
      chk($sformatf("stl_sig_c%0d", c), 32'(ALU_Signals), 32'h0010);
      tick();
    end
    ex_stall = 1'b0;
    chk("stl_done", 32'(ex_valid), 32'h0);

    // undefined and no-ALU opcodes
    id_valid = 1'b1; id_opcode = 5'd25;
    tick();
    chk("ill_sig", 32'(ALU_Signals), 32'h0);
    chk("ill_flag", 32'(ex_illegal), 32'h1);
    chk("ill_valid", 32'(ex_valid), 32'h1);
    id_opcode = 5'd16;
    tick();
    chk("beq_sig", 32'(ALU_Signals), 32'h0);
    chk("beq_ill", 32'(ex_illegal), 32'h0);

    // reset in the middle of a divide
    id_opcode = 5'd3;
    tick();
    id_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rdiv_sig", 32'(ALU_Signals), 32'h0);
    chk("rdiv_valid", 32'(ex_valid), 32'h0);
    chk("rdiv_flags", 32'(flags_q), 32'h0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rdiv_nofire_%0d", c), 32'(ex_fire), 32'h0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
